// File: rtl/speck_ti_pkg.sv
// Shared definitions for the 3-share TI SPECK128/128 datapath: share-bundle layout
// and the masking-stage FSM encoding, used by the masking stage, speck_toplevel and benches.
package speck_ti_pkg;

  localparam int SHARE_W   = 128;
  localparam int BUNDLE_W  = 768;
  localparam int RND_BITS  = 512;

  localparam int KEY_C_LSB  = 640;
  localparam int DATA_A_LSB = 512;
  localparam int KEY_A_LSB  = 384;
  localparam int DATA_B_LSB = 256;
  localparam int KEY_B_LSB  = 128;
  localparam int DATA_C_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_COMBINE = 3'd2,
    ST_START   = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/speck_ti_rnd_collector.sv
// Gathers RND_BITS of fresh randomness one RND_W word at a time; word n lands at
// bit offset n*RND_W. full flags the transfer that completes the buffer.
module speck_ti_rnd_collector
  import speck_ti_pkg::*;
#(
  parameter int RND_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic                rnd_valid,
  input  logic [RND_W-1:0]    rnd_data,
  output logic [RND_BITS-1:0] rnd_buf,
  output logic                full
);

  localparam int N_RND = RND_BITS / RND_W;
  localparam int CNT_W = $clog2(N_RND);

  logic [CNT_W-1:0] cnt;
  logic             take;

  assign take = en & rnd_valid;
  assign full = take & (cnt == CNT_W'(N_RND - 1));

  // Word counter and buffer; clear wipes the randomness once it has been consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= {CNT_W{1'b0}};
      rnd_buf <= {RND_BITS{1'b0}};
    end else if (clear) begin
      cnt     <= {CNT_W{1'b0}};
      rnd_buf <= {RND_BITS{1'b0}};
    end else if (take) begin
      rnd_buf[cnt*RND_W +: RND_W] <= rnd_data;
      cnt                         <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/speck_ti_share_gen.sv
// Masking stage: splits one plaintext/key pair into three Boolean shares using fresh
// randomness and holds the 768-bit bundle for the core until it reports done.
module speck_ti_share_gen
  import speck_ti_pkg::*;
#(
  parameter int RND_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [SHARE_W-1:0]  plaintext,
  input  logic [SHARE_W-1:0]  key,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [RND_W-1:0]    rnd_data,
  output logic [BUNDLE_W-1:0] d_out,
  output logic                core_start,
  input  logic                core_done,
  output logic                busy
);

  state_t                state;
  state_t                state_nxt;
  logic [SHARE_W-1:0]    pt_r;
  logic [SHARE_W-1:0]    key_r;
  logic                  core_done_q;
  logic [RND_BITS-1:0]   rnd_buf;
  logic                  full;
  logic                  accept;
  logic                  done_edge;
  logic                  clear;
  logic [SHARE_W-1:0]    ra_d, ra_k, rb_d, rb_k;

  assign accept    = (state == ST_IDLE) & pt_valid & pt_ready;
  assign done_edge = core_done & ~core_done_q;
  assign clear     = accept | (state == ST_COMBINE);

  assign ra_d = rnd_buf[0 +: SHARE_W];
  assign ra_k = rnd_buf[SHARE_W +: SHARE_W];
  assign rb_d = rnd_buf[2*SHARE_W +: SHARE_W];
  assign rb_k = rnd_buf[3*SHARE_W +: SHARE_W];

  speck_ti_rnd_collector #(.RND_W(RND_W)) u_collector (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .en        (rnd_ready),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_buf   (rnd_buf),
    .full      (full)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_COLLECT;
        else        state_nxt = ST_IDLE;
      end
      ST_COLLECT: begin
        if (full) state_nxt = ST_COMBINE;
        else      state_nxt = ST_COLLECT;
      end
      ST_COMBINE: state_nxt = ST_START;
      ST_START:   state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (done_edge) state_nxt = ST_IDLE;
        else           state_nxt = ST_HOLD;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State and handshake outputs, registered from the next state so none is combinational.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pt_ready    <= 1'b1;
      rnd_ready   <= 1'b0;
      busy        <= 1'b0;
      core_start  <= 1'b0;
      core_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      pt_ready    <= (state_nxt == ST_IDLE);
      rnd_ready   <= (state_nxt == ST_COLLECT);
      busy        <= (state_nxt != ST_IDLE);
      core_start  <= (state_nxt == ST_START);
      core_done_q <= core_done;
    end
  end

  // Secret capture, share XOR and bundle hold; unmasked values are wiped as soon as they are split.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pt_r  <= {SHARE_W{1'b0}};
      key_r <= {SHARE_W{1'b0}};
      d_out <= {BUNDLE_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pt_r  <= plaintext;
            key_r <= key;
          end
        end
        ST_COMBINE: begin
          d_out[KEY_C_LSB  +: SHARE_W] <= key_r ^ ra_k ^ rb_k;
          d_out[DATA_A_LSB +: SHARE_W] <= ra_d;
          d_out[KEY_A_LSB  +: SHARE_W] <= ra_k;
          d_out[DATA_B_LSB +: SHARE_W] <= rb_d;
          d_out[KEY_B_LSB  +: SHARE_W] <= rb_k;
          d_out[DATA_C_LSB +: SHARE_W] <= pt_r ^ ra_d ^ rb_d;
          pt_r  <= {SHARE_W{1'b0}};
          key_r <= {SHARE_W{1'b0}};
        end
        ST_HOLD: begin
          if (done_edge) d_out <= {BUNDLE_W{1'b0}};
        end
        default: ;
      endcase
    end
  end

endmodule
